// File: rtl/npu_pkg.sv
// Shared NPU types and width defaults for the PE and its feeder.
// Holds no logic, so it adds no latency and has no backpressure.
package npu_pkg;
  localparam int NPU_DATA_WIDTH = 8;
  localparam int NPU_ACC_WIDTH  = 20;
  localparam int NPU_ADDR_WIDTH = 10;
  localparam int NPU_LEN_WIDTH  = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_BIAS_RD,
    S_BIAS_LAT,
    S_STREAM,
    S_WAIT_RES,
    S_WRITE,
    S_DONE
  } feeder_state_t;
endpackage

// File: rtl/npu_feed_agen.sv
// Feeder address generator: latched config, k/n/wp counters, buffer addresses.
// Addresses are combinational from the counters; it stalls only when beat/next_neuron are low.
module npu_feed_agen
  import npu_pkg::*;
#(
  parameter int ADDR_WIDTH = NPU_ADDR_WIDTH,
  parameter int LEN_WIDTH  = NPU_LEN_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic                  beat,
  input  logic                  next_neuron,
  input  logic [LEN_WIDTH-1:0]  len,
  input  logic [LEN_WIDTH-1:0]  num,
  input  logic [ADDR_WIDTH-1:0] feat_base,
  input  logic [ADDR_WIDTH-1:0] w_base,
  input  logic [ADDR_WIDTH-1:0] b_base,
  input  logic [ADDR_WIDTH-1:0] out_base,
  output logic [ADDR_WIDTH-1:0] feat_addr,
  output logic [ADDR_WIDTH-1:0] w_addr,
  output logic [ADDR_WIDTH-1:0] b_addr,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic                  last_beat,
  output logic                  last_neuron
);
  logic [LEN_WIDTH-1:0]  len_q, num_q, k_q, n_q;
  logic [ADDR_WIDTH-1:0] fb_q, wb_q, bb_q, ob_q, wp_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q <= '0;
      num_q <= '0;
      k_q   <= '0;
      n_q   <= '0;
      fb_q  <= '0;
      wb_q  <= '0;
      bb_q  <= '0;
      ob_q  <= '0;
      wp_q  <= '0;
    end else if (load) begin
      len_q <= len;
      num_q <= num;
      fb_q  <= feat_base;
      wb_q  <= w_base;
      bb_q  <= b_base;
      ob_q  <= out_base;
      k_q   <= '0;
      n_q   <= '0;
      wp_q  <= '0;
    end else begin
      // wp runs across neurons: weights are stored row-major, one row per neuron
      if (beat) begin
        wp_q <= wp_q + ADDR_WIDTH'(1);
        k_q  <= last_beat ? '0 : k_q + LEN_WIDTH'(1);
      end
      if (next_neuron) n_q <= n_q + LEN_WIDTH'(1);
    end
  end

  assign last_beat   = (k_q == len_q - LEN_WIDTH'(1));
  assign last_neuron = (n_q == num_q - LEN_WIDTH'(1));
  assign feat_addr   = fb_q + ADDR_WIDTH'(k_q);
  assign w_addr      = wb_q + wp_q;
  assign b_addr      = bb_q + ADDR_WIDTH'(n_q);
  assign out_addr    = ob_q + ADDR_WIDTH'(n_q);
endmodule

// File: rtl/npu_pe_feeder.sv
// Streams bias/feature/weight bursts into one npu_pe and writes each result back.
// PE beats trail the reads by 2 cycles; no backpressure, the job stalls only in WAIT_RES.
module npu_pe_feeder
  import npu_pkg::*;
#(
  parameter int DATA_WIDTH = NPU_DATA_WIDTH,
  parameter int ACC_WIDTH  = NPU_ACC_WIDTH,
  parameter int ADDR_WIDTH = NPU_ADDR_WIDTH,
  parameter int LEN_WIDTH  = NPU_LEN_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_start,
  input  logic [LEN_WIDTH-1:0]  i_len,
  input  logic [LEN_WIDTH-1:0]  i_num,
  input  logic [ADDR_WIDTH-1:0] i_feat_base,
  input  logic [ADDR_WIDTH-1:0] i_w_base,
  input  logic [ADDR_WIDTH-1:0] i_b_base,
  input  logic [ADDR_WIDTH-1:0] i_out_base,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_err,
  output logic                  o_fmem_re,
  output logic [ADDR_WIDTH-1:0] o_fmem_addr,
  input  logic [DATA_WIDTH-1:0] i_fmem_rdata,
  output logic                  o_wmem_re,
  output logic [ADDR_WIDTH-1:0] o_wmem_addr,
  input  logic [DATA_WIDTH-1:0] i_wmem_rdata,
  output logic                  o_bmem_re,
  output logic [ADDR_WIDTH-1:0] o_bmem_addr,
  input  logic [ACC_WIDTH-1:0]  i_bmem_rdata,
  output logic                  o_omem_we,
  output logic [ADDR_WIDTH-1:0] o_omem_addr,
  output logic [DATA_WIDTH-1:0] o_omem_wdata,
  output logic                  o_pe_valid,
  output logic                  o_pe_last,
  output logic [DATA_WIDTH-1:0] o_pe_feature,
  output logic [DATA_WIDTH-1:0] o_pe_weight,
  output logic [ACC_WIDTH-1:0]  o_pe_bias,
  input  logic                  i_pe_valid,
  input  logic [DATA_WIDTH-1:0] i_pe_result
);
  feeder_state_t         state_q, state_d;
  logic                  zero_cfg, start_acc, last_beat, last_neuron;
  logic [ADDR_WIDTH-1:0] feat_addr, w_addr, b_addr, out_addr;
  logic                  rd_vld_q, rd_last_q;
  logic [DATA_WIDTH-1:0] result_q;

  assign zero_cfg  = (i_len == '0) || (i_num == '0);
  assign start_acc = (state_q == S_IDLE) && i_start;

  npu_feed_agen #(.ADDR_WIDTH(ADDR_WIDTH), .LEN_WIDTH(LEN_WIDTH)) u_agen (
    .clk         (clk),
    .rst_n       (rst_n),
    .load        (start_acc && !zero_cfg),
    .beat        (state_q == S_STREAM),
    .next_neuron (state_q == S_WRITE),
    .len         (i_len),
    .num         (i_num),
    .feat_base   (i_feat_base),
    .w_base      (i_w_base),
    .b_base      (i_b_base),
    .out_base    (i_out_base),
    .feat_addr   (feat_addr),
    .w_addr      (w_addr),
    .b_addr      (b_addr),
    .out_addr    (out_addr),
    .last_beat   (last_beat),
    .last_neuron (last_neuron)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:     if (i_start) state_d = zero_cfg ? S_DONE : S_BIAS_RD;
      S_BIAS_RD:  state_d = S_BIAS_LAT;
      S_BIAS_LAT: state_d = S_STREAM;
      S_STREAM:   if (last_beat) state_d = S_WAIT_RES;
      S_WAIT_RES: if (i_pe_valid) state_d = S_WRITE;
      S_WRITE:    state_d = last_neuron ? S_DONE : S_BIAS_RD;
      S_DONE:     state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  // Addresses and write data are gated so idle buses sit at zero
  always_comb begin
    o_busy       = (state_q != S_IDLE);
    o_done       = (state_q == S_DONE);
    o_fmem_re    = (state_q == S_STREAM);
    o_wmem_re    = (state_q == S_STREAM);
    o_bmem_re    = (state_q == S_BIAS_RD);
    o_omem_we    = (state_q == S_WRITE);
    o_fmem_addr  = o_fmem_re ? feat_addr : '0;
    o_wmem_addr  = o_wmem_re ? w_addr : '0;
    o_bmem_addr  = o_bmem_re ? b_addr : '0;
    o_omem_addr  = o_omem_we ? out_addr : '0;
    o_omem_wdata = o_omem_we ? result_q : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_vld_q     <= 1'b0;
      rd_last_q    <= 1'b0;
      o_pe_valid   <= 1'b0;
      o_pe_last    <= 1'b0;
      o_pe_feature <= '0;
      o_pe_weight  <= '0;
      o_pe_bias    <= '0;
      result_q     <= '0;
      o_err        <= 1'b0;
    end else begin
      rd_vld_q     <= (state_q == S_STREAM);
      rd_last_q    <= (state_q == S_STREAM) && last_beat;
      o_pe_valid   <= rd_vld_q;
      o_pe_last    <= rd_last_q;
      o_pe_feature <= rd_vld_q ? i_fmem_rdata : '0;
      o_pe_weight  <= rd_vld_q ? i_wmem_rdata : '0;
      if (state_q == S_BIAS_LAT) o_pe_bias <= i_bmem_rdata;
      if ((state_q == S_WAIT_RES) && i_pe_valid) result_q <= i_pe_result;
      if (start_acc)                                    o_err <= zero_cfg;
      else if (i_pe_valid && (state_q != S_WAIT_RES))  o_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_npu_pe_feeder.sv
module tb_npu_pe_feeder;
  typedef int iq_t[$];

  typedef struct {
    int k, n, fb, wb, bb, ob;
    int exp_err;
    int exp_nwr;
    int exp_res0;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_start;
  logic [7:0]  i_len, i_num;
  logic [9:0]  i_feat_base, i_w_base, i_b_base, i_out_base;
  logic        o_busy, o_done, o_err;
  logic        o_fmem_re, o_wmem_re, o_bmem_re, o_omem_we;
  logic [9:0]  o_fmem_addr, o_wmem_addr, o_bmem_addr, o_omem_addr;
  logic [7:0]  i_fmem_rdata, i_wmem_rdata, o_omem_wdata;
  logic [19:0] i_bmem_rdata;
  logic        o_pe_valid, o_pe_last;
  logic [7:0]  o_pe_feature, o_pe_weight;
  logic [19:0] o_pe_bias;
  logic        i_pe_valid;
  logic [7:0]  i_pe_result;

  always #5 clk = ~clk;

  npu_pe_feeder dut (
    .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_len(i_len), .i_num(i_num),
    .i_feat_base(i_feat_base), .i_w_base(i_w_base), .i_b_base(i_b_base), .i_out_base(i_out_base),
    .o_busy(o_busy), .o_done(o_done), .o_err(o_err),
    .o_fmem_re(o_fmem_re), .o_fmem_addr(o_fmem_addr), .i_fmem_rdata(i_fmem_rdata),
    .o_wmem_re(o_wmem_re), .o_wmem_addr(o_wmem_addr), .i_wmem_rdata(i_wmem_rdata),
    .o_bmem_re(o_bmem_re), .o_bmem_addr(o_bmem_addr), .i_bmem_rdata(i_bmem_rdata),
    .o_omem_we(o_omem_we), .o_omem_addr(o_omem_addr), .o_omem_wdata(o_omem_wdata),
    .o_pe_valid(o_pe_valid), .o_pe_last(o_pe_last), .o_pe_feature(o_pe_feature),
    .o_pe_weight(o_pe_weight), .o_pe_bias(o_pe_bias),
    .i_pe_valid(i_pe_valid), .i_pe_result(i_pe_result)
  );

  logic all_or;
  assign all_or = |{o_busy, o_done, o_err, o_fmem_re, o_fmem_addr, o_wmem_re, o_wmem_addr,
                    o_bmem_re, o_bmem_addr, o_omem_we, o_omem_addr, o_omem_wdata,
                    o_pe_valid, o_pe_last, o_pe_feature, o_pe_weight, o_pe_bias};

  // Buffer SRAMs: synchronous read, one cycle latency
  logic [7:0]  fmem [1024];
  logic [7:0]  wmem [1024];
  logic [19:0] bmem [1024];
  always @(posedge clk) begin
    if (o_fmem_re) i_fmem_rdata <= fmem[o_fmem_addr];
    if (o_wmem_re) i_wmem_rdata <= wmem[o_wmem_addr];
    if (o_bmem_re) i_bmem_rdata <= bmem[o_bmem_addr];
  end

  // Behavioural PE: bias + sum(f*w), ReLU, saturate to 127, result 2 cycles after last
  int   acc, acc_nx, dly;
  bit   pe_first;
  logic pe_vld, inj_pv;
  function automatic int clamp8(input int v);
    return (v < 0) ? 0 : ((v > 127) ? 127 : v);
  endfunction
  always_comb acc_nx = (pe_first ? int'($signed(o_pe_bias)) : acc)
                     + int'($signed(o_pe_feature)) * int'($signed(o_pe_weight));
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= 0; dly <= 0; pe_first <= 1'b1; pe_vld <= 1'b0; i_pe_result <= '0;
    end else begin
      pe_vld <= (dly == 1);
      if (dly != 0) dly <= dly - 1;
      if (o_pe_valid) begin
        if (o_pe_last) begin
          i_pe_result <= 8'(clamp8(acc_nx));
          dly <= 2;
          pe_first <= 1'b1;
        end else begin
          acc <= acc_nx;
          pe_first <= 1'b0;
        end
      end
    end
  end
  assign i_pe_valid = pe_vld | inj_pv;

  int n_pass = 0, n_tot = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
  endtask

  task automatic chk_q(input string nm, input iq_t act, input iq_t exp);
    int bad = -1;
    if (act.size() != exp.size()) bad = -2;
    else for (int i = 0; i < act.size(); i++) if (bad == -1 && act[i] != exp[i]) bad = i;
    n_tot++;
    if (bad == -1) n_pass++;
    else if (bad == -2) $display("FAIL %s: got %0d entries, expected %0d", nm, act.size(), exp.size());
    else $display("FAIL %s: entry %0d got %0d, expected %0d", nm, bad, act[bad], exp[bad]);
  endtask

  iq_t f_log, w_log, b_log, wa_log, wd_log;
  iq_t ex_f, ex_w, ex_b, ex_wa, ex_wd;

  // Reference: the whole job computed from buffer contents with plain arithmetic
  task automatic build_model(input int k, input int n, input int fb, input int wb,
                             input int bb, input int ob);
    ex_f = {}; ex_w = {}; ex_b = {}; ex_wa = {}; ex_wd = {};
    if (k == 0 || n == 0) return;
    for (int j = 0; j < n; j++) begin
      int s = int'($signed(bmem[(bb + j) % 1024]));
      ex_b.push_back((bb + j) % 1024);
      for (int i = 0; i < k; i++) begin
        int fa = (fb + i) % 1024;
        int wa = (wb + j * k + i) % 1024;
        ex_f.push_back(fa);
        ex_w.push_back(wa);
        s += int'($signed(fmem[fa])) * int'($signed(wmem[wa]));
      end
      ex_wa.push_back((ob + j) % 1024);
      ex_wd.push_back(clamp8(s));
    end
  endtask

  task automatic run_job(input int k, input int n, input int fb, input int wb, input int bb,
                         input int ob, input int inj_start_c, input int inj_pv_c, input int rst_c);
    int c = 0, done_c = -1, done_cnt = 0, busy0 = 0, busy_after = -1, first_v = -1;
    int beats = 0, runs = 0, lasts = 0, viol = 0;
    bit prev_v = 0, prev_l = 0, zero = (k == 0 || n == 0);
    f_log = {}; w_log = {}; b_log = {}; wa_log = {}; wd_log = {};
    build_model(k, n, fb, wb, bb, ob);
    i_len = 8'(k); i_num = 8'(n);
    i_feat_base = 10'(fb); i_w_base = 10'(wb); i_b_base = 10'(bb); i_out_base = 10'(ob);
    i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
    while (1) begin
      if (o_fmem_re) f_log.push_back(int'(o_fmem_addr));
      if (o_wmem_re) w_log.push_back(int'(o_wmem_addr));
      if (o_bmem_re) b_log.push_back(int'(o_bmem_addr));
      if (o_omem_we) begin
        wa_log.push_back(int'(o_omem_addr));
        wd_log.push_back(int'($signed(o_omem_wdata)));
      end
      if (o_pe_valid) begin
        beats++;
        if (first_v < 0) first_v = c;
        if (!prev_v) runs++;
        if (o_pe_last) lasts++;
        if (prev_v && prev_l) viol++;
      end else if (prev_v) begin
        if (!prev_l) viol++;
        if (o_pe_feature != 0 || o_pe_weight != 0) viol++;
      end
      prev_v = o_pe_valid; prev_l = o_pe_last;
      if (o_done) begin done_cnt++; if (done_c < 0) done_c = c; end
      if (c == 0) busy0 = int'(o_busy);
      if (done_c >= 0 && c == done_c + 1) busy_after = int'(o_busy);
      if (c == rst_c) begin
        rst_n = 1'b0;
        #1;
        chk("async_reset_outputs", int'(all_or), 0);
        chk("reset_no_write", wa_log.size(), 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        return;
      end
      if (done_c >= 0 && c >= done_c + 2) break;
      if (c >= 2000) begin chk("job_timeout", c, -1); break; end
      if (c == inj_start_c) i_start = 1'b1;
      if (c == inj_pv_c) inj_pv = 1'b1;
      @(posedge clk); #1;
      c++;
      i_start = 1'b0; inj_pv = 1'b0;
    end
    chk("done_pulses", done_cnt, 1);
    chk("err_flag", int'(o_err), int'(zero || inj_pv_c >= 0));
    chk("busy_after_start", busy0, 1);
    chk("busy_after_done", busy_after, 0);
    chk_q("feat_addrs", f_log, ex_f);
    chk_q("weight_addrs", w_log, ex_w);
    chk_q("bias_addrs", b_log, ex_b);
    chk_q("out_addrs", wa_log, ex_wa);
    chk_q("out_data", wd_log, ex_wd);
    chk("pe_beats", beats, k * n);
    chk("pe_bursts", runs + 100 * lasts, zero ? 0 : 101 * n);
    chk("burst_shape_violations", viol, 0);
    if (!zero) chk("first_beat_latency", first_v, 4);
  endtask

  vec_t tbl[4];

  initial begin
    rst_n = 1'b0; i_start = 1'b0; inj_pv = 1'b0;
    i_len = '0; i_num = '0; i_feat_base = '0; i_w_base = '0; i_b_base = '0; i_out_base = '0;
    for (int i = 0; i < 1024; i++) begin fmem[i] = '0; wmem[i] = '0; bmem[i] = '0; end
    fmem['h20] = 8'd10; fmem['h21] = 8'd5; fmem['h22] = 8'd2;
    wmem['h30] = 8'd2;  wmem['h31] = -8'sd3; wmem['h32] = 8'd4;
    bmem['h40] = 20'd5;
    fmem['h50] = 8'd2; wmem['h60] = -8'sd10; bmem['h70] = 20'd5;
    tbl[0] = '{3, 1, 'h20, 'h30, 'h40, 'h80, 0, 1, 18};
    tbl[1] = '{1, 1, 'h50, 'h60, 'h70, 'h90, 0, 1, 0};
    tbl[2] = '{0, 1, 'h20, 'h30, 'h40, 'h80, 1, 0, 0};
    tbl[3] = '{2, 0, 'h20, 'h30, 'h40, 'h80, 1, 0, 0};

    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs_zero", int'(all_or), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int t = 0; t < 4; t++) begin
      run_job(tbl[t].k, tbl[t].n, tbl[t].fb, tbl[t].wb, tbl[t].bb, tbl[t].ob, -1, -1, -1);
      chk($sformatf("tbl%0d_err", t), int'(o_err), tbl[t].exp_err);
      chk($sformatf("tbl%0d_writes", t), wa_log.size(), tbl[t].exp_nwr);
      if (tbl[t].exp_nwr > 0) begin
        chk($sformatf("tbl%0d_result", t), (wd_log.size() > 0) ? wd_log[0] : -999, tbl[t].exp_res0);
        chk($sformatf("tbl%0d_out_addr", t), (wa_log.size() > 0) ? wa_log[0] : -999, tbl[t].ob);
      end else begin
        chk($sformatf("tbl%0d_read_strobes", t), f_log.size() + w_log.size() + b_log.size(), 0);
      end
    end

    for (int i = 0; i < 1024; i++) begin
      int b = int'($urandom_range(0, 400)) - 200;
      fmem[i] = 8'($urandom_range(0, 255));
      wmem[i] = 8'($urandom_range(0, 255));
      bmem[i] = b[19:0];
    end

    // K=2, N=3: weight pointer walks 0x10..0x15 across neurons
    run_job(2, 3, 'h100, 'h10, 'h200, 'h300, -1, -1, -1);
    begin
      iq_t wexp;
      wexp = {};
      for (int i = 0; i < 6; i++) wexp.push_back('h10 + i);
      chk_q("k2n3_weight_walk", w_log, wexp);
    end

    // Address wrap at the top of the buffers
    run_job(4, 2, 1022, 1020, 1023, 1023, -1, -1, -1);

    // Start while busy is ignored; stray PE valid only flags an error
    run_job(4, 2, 'h40, 'h80, 'h20, 'h60, 3, -1, -1);
    run_job(4, 2, 'h40, 'h80, 'h20, 'h60, -1, 4, -1);

    // Reset mid-STREAM, then a clean job
    run_job(5, 2, 'h10, 'h20, 'h30, 'h40, -1, -1, 5);
    run_job(3, 2, 'h10, 'h20, 'h30, 'h40, -1, -1, -1);

    for (int j = 0; j < 8; j++) begin
      run_job(int'($urandom_range(1, 6)), int'($urandom_range(1, 4)),
              int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)),
              int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)), -1, -1, -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
